// File: rtl/fsm_9_pkg.sv
// Shared types for the "1011" sequence detector: Moore/Mealy state encodings and the reference pattern.
package fsm_9_pkg;

    localparam int unsigned MOORE_W = 3;
    localparam int unsigned MEALY_W = 2;

    typedef enum logic [MOORE_W-1:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } moore_state_t;

    typedef enum logic [MEALY_W-1:0] {
        M0 = 2'd0,
        M1 = 2'd1,
        M2 = 2'd2,
        M3 = 2'd3
    } mealy_state_t;

    localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/fsm_9_detector.sv
// Serial "1011" detector: a Moore machine (flag one cycle after the match)
// and a Mealy machine (flag during the completing bit) watching the same stream.
module fsm_9_detector
    import fsm_9_pkg::*;
#(
    parameter bit OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic y,
    output logic y1
);

    moore_state_t moore_state;
    moore_state_t moore_next;
    mealy_state_t mealy_state;
    mealy_state_t mealy_next;

    // Moore state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            moore_state <= S0;
        end else begin
            moore_state <= moore_next;
        end
    end

    // Moore next state; unused codes fall back to S0
    always_comb begin
        moore_next = S0;
        case (moore_state)
            S0:      moore_next = x ? S1 : S0;
            S1:      moore_next = x ? S1 : S2;
            S2:      moore_next = x ? S3 : S0;
            S3:      moore_next = x ? S4 : S2;
            S4:      moore_next = x ? S1 : (OVERLAP ? S2 : S0);
            default: moore_next = S0;
        endcase
    end

    assign y = (moore_state == S4);

    // Mealy state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mealy_state <= M0;
        end else begin
            mealy_state <= mealy_next;
        end
    end

    // Mealy next state; a match either keeps the trailing "1" or restarts
    always_comb begin
        mealy_next = M0;
        case (mealy_state)
            M0:      mealy_next = x ? M1 : M0;
            M1:      mealy_next = x ? M1 : M2;
            M2:      mealy_next = x ? M3 : M0;
            M3:      mealy_next = x ? (OVERLAP ? M1 : M0) : M2;
            default: mealy_next = M0;
        endcase
    end

    assign y1 = rst & (mealy_state == M3) & x;

endmodule

// File: tb/tb_fsm_9_detector.sv
// Bench for fsm_9_detector: overlapping and non-overlapping instances checked against a bit-history model.
module tb_fsm_9_detector;
    import fsm_9_pkg::*;

    typedef struct packed {
        logic y_ov;
        logic y_no;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic x;
    logic y, y1, y_no, y1_no;

    int checks = 0;
    int errors = 0;

    logic [2:0] h_ov, h_no;
    int         n_ov, n_no;
    logic       cur_y_ov, cur_y_no;
    exp_t       q[$];

    always #5 clk = ~clk;

    fsm_9_detector #(.OVERLAP(1'b1)) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .y1(y1)
    );

    fsm_9_detector #(.OVERLAP(1'b0)) dut_no (
        .clk(clk), .rst(rst), .x(x), .y(y_no), .y1(y1_no)
    );

    task automatic check(input string tag, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
            $error("check %s failed", tag);
        end
    endtask

    function automatic logic hit(input logic [2:0] h, input int n, input logic b);
        logic [3:0] pat;
        pat = PATTERN;
        return (n >= 3) && ({h, b} == pat);
    endfunction

    task automatic sync();
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: observed empty queue expected one entry");
        end else begin
            e = q.pop_front();
            cur_y_ov = e.y_ov;
            cur_y_no = e.y_no;
            check("y_ov", 3'(y), 3'(cur_y_ov));
            check("y_no", 3'(y_no), 3'(cur_y_no));
        end
    endtask

    task automatic peek(input logic b);
        x = b;
        #1;
        check("y1_ov", 3'(y1), 3'(hit(h_ov, n_ov, b)));
        check("y1_no", 3'(y1_no), 3'(hit(h_no, n_no, b)));
        check("y_hold_ov", 3'(y), 3'(cur_y_ov));
        check("y_hold_no", 3'(y_no), 3'(cur_y_no));
    endtask

    task automatic commit(input logic b);
        exp_t e;
        e.y_ov = hit(h_ov, n_ov, b);
        e.y_no = hit(h_no, n_no, b);
        h_ov = {h_ov[1:0], b};
        if (n_ov < 3) n_ov++;
        if (e.y_no) begin
            h_no = 3'b000;
            n_no = 0;
        end else begin
            h_no = {h_no[1:0], b};
            if (n_no < 3) n_no++;
        end
        q.push_back(e);
    endtask

    task automatic step(input logic b);
        sync();
        peek(b);
        commit(b);
    endtask

    // Asynchronous reset pulse of 3 ns taken between clock edges
    task automatic do_reset();
        x = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_y_ov", 3'(y), 3'd0);
        check("rst_y_no", 3'(y_no), 3'd0);
        check("rst_y1_ov", 3'(y1), 3'd0);
        check("rst_moore", 3'(dut.moore_state), 3'd0);
        check("rst_mealy", 3'(dut.mealy_state), 3'd0);
        #2;
        rst = 1'b1;
        h_ov = 3'b000; n_ov = 0;
        h_no = 3'b000; n_no = 0;
        cur_y_ov = 1'b0; cur_y_no = 1'b0;
        q.delete();
        q.push_back(exp_t'(2'b00));
    endtask

    initial begin
        logic [2:0] path [8];
        logic [7:0] basic;
        logic [6:0] ovl;
        logic [8:0] miss;

        path  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd0, 3'd1, 3'd2};
        basic = 8'b1011_0010;
        ovl   = 7'b1011011;
        miss  = 9'b1001_1101_0;

        rst = 1'b0;
        x = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            x = ~x;
            #1;
            check("hold_y_ov", 3'(y), 3'd0);
            check("hold_y_no", 3'(y_no), 3'd0);
            check("hold_y1_ov", 3'(y1), 3'd0);
            check("hold_y1_no", 3'(y1_no), 3'd0);
        end
        do_reset();

        // Basic stream with Moore state path
        for (int i = 0; i < 8; i++) begin
            sync();
            if (i > 0) check("moore_path", 3'(dut.moore_state), path[i-1]);
            peek(basic[7-i]);
            commit(basic[7-i]);
        end
        sync();
        check("moore_path", 3'(dut.moore_state), path[7]);

        // Overlapping stream
        do_reset();
        for (int i = 6; i >= 0; i--) step(ovl[i]);
        sync();

        // Near misses
        do_reset();
        for (int i = 8; i >= 0; i--) step(miss[i]);
        sync();

        // Reset while "101" is held with x=1
        do_reset();
        step(1'b1);
        step(1'b0);
        step(1'b1);
        sync();
        peek(1'b1);
        do_reset();
        step(1'b1);
        step(1'b1);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        sync();

        // y1 follows x within a cycle while in "101"
        do_reset();
        step(1'b1);
        step(1'b0);
        step(1'b1);
        sync();
        peek(1'b0);
        peek(1'b1);
        peek(1'b0);
        commit(1'b0);
        sync();

        // Random stream
        do_reset();
        for (int i = 0; i < 60; i++) step(1'($urandom_range(0, 1)));
        sync();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_9_detector.md
Name: fsm_9_detector

Overview:
- Serial "1011" sequence detector; one bit `x` is sampled per rising clock edge.
- Two detectors run in parallel on the same input:
  - Moore machine drives `y` (registered, one cycle after the completing bit).
  - Mealy machine drives `y1` (combinational, in the same cycle as the completing bit).
- Used as a reference FSM block for comparing Moore and Mealy timing on one bit stream.

Parameters:
- OVERLAP, 1, 1 = overlapping detection (the suffix of a match is reused); 0 = restart from empty after each match.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset (0 = reset asserted)
- x    input  1  serial data bit, sampled on the rising edge of clk
- y    output 1  Moore detect flag; high for exactly the cycle after "1011" completes
- y1   output 1  Mealy detect flag; high while the Moore-side state is "101" seen and x=1

Behaviour:
- Reset, while rst=0:
  - Moore state = S0, Mealy state = M0.
  - y=0; y1 forced to 0 regardless of x.
  - Reset takes effect immediately (asynchronous); release is sampled on the next clk edge.
- Moore states and y value: S0 idle (y=0), S1 "1" (0), S2 "10" (0), S3 "101" (0), S4 "1011" (y=1).
- Moore transitions (x=0 / x=1):
  - S0: S0 / S1
  - S1: S2 / S1
  - S2: S0 / S3
  - S3: S2 / S4
  - S4: OVERLAP=1 → S2 / S1; OVERLAP=0 → S0 / S1
- y is decoded from the state register only: y = (state==S4). It never glitches with x.
- Mealy states: M0 idle, M1 "1", M2 "10", M3 "101".
- Mealy transitions (x=0 / x=1):
  - M0: M0 / M1
  - M1: M2 / M1
  - M2: M0 / M3
  - M3: M2 / (OVERLAP=1 → M1; OVERLAP=0 → M0)
- y1 = rst & (state==M3) & x. It is combinational and follows x within the cycle.
- Latency: y1 rises in the cycle in which the 4th bit is presented. y rises one clock later and lasts exactly 1 cycle, unless a new match completes back-to-back.
- Back-to-back matches:
  - Overlapping stream "1011011" gives two y pulses, 3 cycles apart. With OVERLAP=0 it gives one.
  - Two consecutive y-high cycles are impossible (minimum match spacing is 3 bits).
- Reset mid-pattern discards all partial history. After release, a full 4-bit pattern is required before any flag asserts.
- Encoding:
  - Moore state register 3 bits, Mealy state register 2 bits, binary encoding.
  - Unused Moore codes 5–7 return to S0 on the next clock, with y=0.

Decomposition:
- Shared package fsm_9_pkg holds:
  - the Moore state enum (S0..S4) and the Mealy state enum (M0..M3);
  - the constant PATTERN = 4'b1011 for bench reference.
- The two machines are independent. Implement each as its own always-block pair (state register + next-state logic) in the top module; no sub-module is needed.
- Optional sub-module fsm_9_mealy_core if reuse is wanted.

Test Plan:
- Reset check: rst=0, x toggling → y=0, y1=0 throughout. Release rst between edges → both flags stay 0 until a full pattern arrives.
- Basic stream: x=1,0,1,1,0,0,1,0, one bit per cycle after reset release:
  - y1=1 only while the 4th bit (x=1) is applied;
  - y=1 for exactly the following cycle;
  - both flags 0 elsewhere;
  - Moore state path S1,S2,S3,S4,S2,S0,S1,S2.
- Overlap: x=1,0,1,1,0,1,1 with OVERLAP=1 → two y pulses (after bits 4 and 7) and two y1 pulses. Same stream with OVERLAP=0 → one pulse of each.
- Near misses: x=1,0,0,1,1,1,0,1,0 (no "1011" substring) → y=0 and y1=0 for all cycles.
- Async reset mid-pattern: apply "101", pulse rst low for 3 ns between edges, then x=1 → no y1 or y pulse; the next full "1011" is detected normally.
- y1 combinational: in state M3, toggle x 0→1→0 within one cycle → y1 follows x with no clock edge. y is unchanged until the edge.
